md_unit: RTL and testbench

- Multi-cycle multiply/divide unit with HI/LO registers. Sits in the EX stage directly downstream of grf: operands arrive from GRF read ports R1/R2 (after forwarding muxes).
- Provides busy status to the hazard controller, and mfhi/mflo read data to the EX result mux.
- Models MIPS mult/multu/div/divu latency so the pipeline stalls correctly.

---
 rtl/md_unit_pkg.sv | 29 ++
 rtl/md_unit.sv | 134 +++++++++++++
 tb/tb_md_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared md_op encoding and helpers for the multiply/divide unit and the controller decode.
package md_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned MD_OP_W = 4;

    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE = 4'd0,
        MULT    = 4'd1,
        MULTU   = 4'd2,
        DIV     = 4'd3,
        DIVU    = 4'd4,
        MFHI    = 4'd5,
        MFLO    = 4'd6,
        MTHI    = 4'd7,
        MTLO    = 4'd8
    } md_op_e;

    // True for the ops that occupy the unit for multiple cycles.
    function automatic logic is_launch_op(input logic [MD_OP_W-1:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

    // True for the multiply subset (selects MULT_CYCLES latency).
    function automatic logic is_mult_op(input logic [MD_OP_W-1:0] op);
        return (op == MULT) || (op == MULTU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers; models MIPS mult/div latency.
module md_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        start,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);
    import md_unit_pkg::*;

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    logic                r_busy;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic [XLEN-1:0]     r_pend_hi;
    logic [XLEN-1:0]     r_pend_lo;
    logic                r_pend_wr;

    logic [2*XLEN-1:0]   w_prod_s;
    logic [2*XLEN-1:0]   w_prod_u;
    logic signed [XLEN-1:0] w_as;
    logic signed [XLEN-1:0] w_bs;
    logic signed [XLEN-1:0] w_quo_s;
    logic signed [XLEN-1:0] w_rem_s;
    logic [XLEN-1:0]     w_b_safe;
    logic [XLEN-1:0]     w_quo_u;
    logic [XLEN-1:0]     w_rem_u;
    logic                w_b_zero;
    logic [XLEN-1:0]     w_res_hi;
    logic [XLEN-1:0]     w_res_lo;
    logic                w_res_wr;
    logic [CNT_W-1:0]    w_res_cnt;

    // Behavioural arithmetic; divisor forced to 1 on zero so no X reaches the pending regs.
    assign w_prod_s = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
    assign w_prod_u = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    assign w_b_zero = (b == '0);
    assign w_b_safe = w_b_zero ? XLEN'(1) : b;
    assign w_as     = $signed(a);
    assign w_bs     = $signed(w_b_safe);
    assign w_quo_s  = w_as / w_bs;
    assign w_rem_s  = w_as % w_bs;
    assign w_quo_u  = a / w_b_safe;
    assign w_rem_u  = a % w_b_safe;

    // Select the pending result, writeback enable and latency for a launching op.
    always_comb begin
        w_res_hi  = '0;
        w_res_lo  = '0;
        w_res_wr  = 1'b0;
        w_res_cnt = is_mult_op(md_op) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        if (md_op == MULT) begin
            w_res_hi = w_prod_s[2*XLEN-1:XLEN];
            w_res_lo = w_prod_s[XLEN-1:0];
            w_res_wr = 1'b1;
        end else if (md_op == MULTU) begin
            w_res_hi = w_prod_u[2*XLEN-1:XLEN];
            w_res_lo = w_prod_u[XLEN-1:0];
            w_res_wr = 1'b1;
        end else if (md_op == DIV) begin
            w_res_hi = w_rem_s;
            w_res_lo = w_quo_s;
            w_res_wr = !w_b_zero;
        end else if (md_op == DIVU) begin
            w_res_hi = w_rem_u;
            w_res_lo = w_quo_u;
            w_res_wr = !w_b_zero;
        end
    end

    // Launch, countdown, writeback and mthi/mtlo; new ops are ignored while busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
        end else if (r_busy) begin
            if (r_cnt == CNT_W'(1)) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
                if (r_pend_wr) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end else begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end else if (en) begin
            if (is_launch_op(md_op)) begin
                r_busy    <= 1'b1;
                r_cnt     <= w_res_cnt;
                r_pend_hi <= w_res_hi;
                r_pend_lo <= w_res_lo;
                r_pend_wr <= w_res_wr;
            end else if (md_op == MTHI) begin
                r_hi <= a;
            end else if (md_op == MTLO) begin
                r_lo <= a;
            end
        end
    end

    // Status and read-port outputs.
    always_comb begin
        start   = en && is_launch_op(md_op);
        rd_data = '0;
        if (md_op == MFHI) begin
            rd_data = r_hi;
        end else if (md_op == MFLO) begin
            rd_data = r_lo;
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        start;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int checks;
    int failures;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .en(en), .md_op(md_op), .a(a), .b(b),
        .busy(busy), .start(start), .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; sample/drive 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count sampled busy cycles, bounded.
    task automatic wait_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            step();
        end
    endtask

    task automatic drive(input logic e, input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb);
        en = e; md_op = op; a = va; b = vb;
    endtask

    task automatic test_reset();
        drive(1'b0, MD_NONE, 32'h0, 32'h0);
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
        checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd got=%h exp=0", rd_data); end
    endtask

    task automatic test_mult();
        int n;
        drive(1'b1, MULT, 32'hFFFFFFFF, 32'h00000002);
        #1;
        checks++; if (start !== 1'b1) begin failures++; $display("FAIL mult_start got=%0b exp=1", start); end
        step();
        drive(1'b0, MD_NONE, 32'h0, 32'h0);
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL mult_lo_early got=%h exp=0", lo); end
        wait_busy(n);
        checks++; if (n != 5) begin failures++; $display("FAIL mult_busy_len got=%0d exp=5", n); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL mult_hi got=%h exp=ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL mult_lo got=%h exp=fffffffe", lo); end

        drive(1'b1, MULTU, 32'hFFFFFFFF, 32'h00000002);
        step();
        drive(1'b0, MD_NONE, 32'h0, 32'h0);
        wait_busy(n);
        checks++; if (n != 5) begin failures++; $display("FAIL multu_busy_len got=%0d exp=5", n); end
        checks++; if (hi !== 32'h00000001) begin failures++; $display("FAIL multu_hi got=%h exp=00000001", hi); end
        checks++; if (lo !== 32'hFFFFFFFE) begin failures++; $display("FAIL multu_lo got=%h exp=fffffffe", lo); end
    endtask

    task automatic test_div();
        int n;
        drive(1'b1, DIV, 32'hFFFFFFF9, 32'h00000002);
        step();
        drive(1'b0, MD_NONE, 32'h0, 32'h0);
        wait_busy(n);
        checks++; if (n != 10) begin failures++; $display("FAIL div_busy_len got=%0d exp=10", n); end
        checks++; if (lo !== 32'hFFFFFFFD) begin failures++; $display("FAIL div_lo got=%h exp=fffffffd", lo); end
        checks++; if (hi !== 32'hFFFFFFFF) begin failures++; $display("FAIL div_hi got=%h exp=ffffffff", hi); end

        drive(1'b1, DIVU, 32'd7, 32'd2);
        step();
        drive(1'b0, MD_NONE, 32'h0, 32'h0);
        wait_busy(n);
        checks++; if (n != 10) begin failures++; $display("FAIL divu_busy_len got=%0d exp=10", n); end
        checks++; if (lo !== 32'd3) begin failures++; $display("FAIL divu_lo got=%h exp=3", lo); end
        checks++; if (hi !== 32'd1) begin failures++; $display("FAIL divu_hi got=%h exp=1", hi); end
    endtask

    task automatic test_mt_mf();
        int n;
        drive(1'b1, MTHI, 32'h12345678, 32'h0);
        step();
        checks++; if (hi !== 32'h12345678) begin failures++; $display("FAIL mthi_hi got=%h exp=12345678", hi); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%0b exp=0", busy); end
        drive(1'b1, MFHI, 32'h0, 32'h0);
        #1;
        checks++; if (rd_data !== 32'h12345678) begin failures++; $display("FAIL mfhi_rd got=%h exp=12345678", rd_data); end
        drive(1'b1, MFLO, 32'h0, 32'h0);
        #1;
        checks++; if (rd_data !== 32'd3) begin failures++; $display("FAIL mflo_rd got=%h exp=3", rd_data); end
        drive(1'b1, MD_NONE, 32'h0, 32'h0);
        #1;
        checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL none_rd got=%h exp=0", rd_data); end
        step();
        // Launch MULTU 3*5, then try MTLO while busy.
        drive(1'b1, MULTU, 32'd3, 32'd5);
        step();
        drive(1'b1, MTLO, 32'hDEADBEEF, 32'h0);
        step();
        checks++; if (lo !== 32'd3) begin failures++; $display("FAIL mtlo_busy_lo got=%h exp=3", lo); end
        drive(1'b1, MFLO, 32'h0, 32'h0);
        #1;
        checks++; if (rd_data !== 32'd3) begin failures++; $display("FAIL mflo_busy_rd got=%h exp=3", rd_data); end
        drive(1'b0, MD_NONE, 32'h0, 32'h0);
        wait_busy(n);
        checks++; if (n != 4) begin failures++; $display("FAIL multu2_remaining got=%0d exp=4", n); end
        checks++; if (lo !== 32'd15) begin failures++; $display("FAIL multu2_lo got=%h exp=f", lo); end
        checks++; if (hi !== 32'd0) begin failures++; $display("FAIL multu2_hi got=%h exp=0", hi); end
    endtask

    task automatic test_div_zero();
        int n;
        drive(1'b1, MTHI, 32'h00000055, 32'h0);
        step();
        drive(1'b1, MTLO, 32'hAAAA0000, 32'h0);
        step();
        checks++; if (lo !== 32'hAAAA0000) begin failures++; $display("FAIL dz_mtlo got=%h exp=aaaa0000", lo); end
        drive(1'b1, DIV, 32'd100, 32'd0);
        step();
        drive(1'b0, MD_NONE, 32'h0, 32'h0);
        wait_busy(n);
        checks++; if (n != 10) begin failures++; $display("FAIL dz_busy_len got=%0d exp=10", n); end
        checks++; if (lo !== 32'hAAAA0000) begin failures++; $display("FAIL dz_lo got=%h exp=aaaa0000", lo); end
        checks++; if (hi !== 32'h00000055) begin failures++; $display("FAIL dz_hi got=%h exp=55", hi); end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, MULT, 32'd2, 32'd3);
        step();
        drive(1'b0, MD_NONE, 32'h0, 32'h0);
        step(); step();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%0b exp=0", busy); end
        checks++; if (hi !== 32'h0) begin failures++; $display("FAIL rstmid_hi got=%h exp=0", hi); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL rstmid_lo got=%h exp=0", lo); end
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL rstmid_late_lo got=%h exp=0", lo); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_late_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_en_zero();
        drive(1'b0, MULT, 32'd9, 32'd9);
        #1;
        checks++; if (start !== 1'b0) begin failures++; $display("FAIL en0_start got=%0b exp=0", start); end
        step();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL en0_busy got=%0b exp=0", busy); end
        checks++; if (lo !== 32'h0) begin failures++; $display("FAIL en0_lo got=%h exp=0", lo); end
    endtask

    task automatic test_back_to_back();
        int n;
        drive(1'b1, MULT, 32'h10, 32'h10);
        step();
        // DIVU held from the next cycle: ignored while busy, launches the edge after busy falls.
        drive(1'b1, DIVU, 32'd100, 32'd7);
        wait_busy(n);
        checks++; if (n != 5) begin failures++; $display("FAIL b2b_mult_len got=%0d exp=5", n); end
        checks++; if (lo !== 32'h100) begin failures++; $display("FAIL b2b_mult_lo got=%h exp=100", lo); end
        step();
        drive(1'b0, MD_NONE, 32'h0, 32'h0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_divu_launch got=%0b exp=1", busy); end
        wait_busy(n);
        checks++; if (n != 10) begin failures++; $display("FAIL b2b_divu_len got=%0d exp=10", n); end
        checks++; if (lo !== 32'd14) begin failures++; $display("FAIL b2b_divu_lo got=%h exp=e", lo); end
        checks++; if (hi !== 32'd2) begin failures++; $display("FAIL b2b_divu_hi got=%h exp=2", hi); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        drive(1'b0, MD_NONE, 32'h0, 32'h0);
        test_reset();
        test_mult();
        test_div();
        test_mt_mf();
        test_div_zero();
        test_reset_mid();
        test_en_zero();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
